// File: rtl/sr04_pkg.sv
// Shared constants, FSM state type and channel-search helpers for the
// multi-channel HC-SR04 scan controller.
package sr04_pkg;

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_NORISE = 2'd1;
    localparam logic [1:0] ERR_LONG   = 2'd2;

    // us -> cm: 1130 / 65536 approximates 1/58
    localparam int CM_RECIP = 1130;
    localparam int CM_SHIFT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEAS,
        ST_GAP
    } state_e;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Returns {wrapped, channel}: the next set bit above cur, or the lowest
    // set bit with wrapped = 1 when nothing above cur remains.
    function automatic logic [3:0] next_set(input logic [7:0] m, input logic [2:0] cur);
        logic       found;
        logic [2:0] hi;
        found = 1'b0;
        hi    = cur;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (3'(i) > cur)) begin
                found = 1'b1;
                hi    = 3'(i);
            end
        end
        return found ? {1'b0, hi} : {1'b1, lowest_set(m)};
    endfunction

endpackage

// File: rtl/sr04_cm_conv.sv
// Registered microsecond-to-centimetre conversion; the tag and the valid
// strobe travel alongside so the result fields stay aligned.
module sr04_cm_conv
    import sr04_pkg::*;
#(
    parameter int US_W  = 16,
    parameter int TAG_W = 5
) (
    input  logic             clk_1m,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [US_W-1:0]  in_us,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [US_W-1:0]  out_us,
    output logic [US_W-1:0]  out_cm,
    output logic [TAG_W-1:0] out_tag
);

    logic [31:0]      prod;
    logic             valid_q, valid_d;
    logic [US_W-1:0]  us_q, us_d;
    logic [US_W-1:0]  cm_q, cm_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    assign prod = 32'(in_us) * 32'(CM_RECIP);

    always_comb begin
        valid_d = in_valid;
        us_d    = us_q;
        cm_d    = cm_q;
        tag_d   = tag_q;
        // Result fields hold their last value between strobes
        if (in_valid) begin
            us_d  = in_us;
            cm_d  = US_W'(prod >> CM_SHIFT);
            tag_d = in_tag;
        end
    end

    always_ff @(posedge clk_1m) begin
        if (rst) begin
            valid_q <= 1'b0;
            us_q    <= '0;
            cm_q    <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            us_q    <= us_d;
            cm_q    <= cm_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q;
    assign out_us    = us_q;
    assign out_cm    = cm_q;
    assign out_tag   = tag_q;

endmodule

// File: rtl/sr04_scan_ctrl.sv
// Round-robin HC-SR04 scanner: triggers each enabled sensor in turn, times
// the echo in 1 us cycles and publishes one converted result per ping.
module sr04_scan_ctrl
    import sr04_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int TRIG_US     = 10,
    parameter int RISE_TO_US  = 2000,
    parameter int ECHO_MAX_US = 25000,
    parameter int GAP_US      = 60000,
    parameter int US_W        = 16
) (
    input  logic              clk_1m,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              start,
    input  logic [CH_NUM-1:0] ch_mask,
    input  logic [CH_NUM-1:0] echo,
    output logic [CH_NUM-1:0] trig,
    output logic              busy,
    output logic              res_valid,
    output logic [2:0]        res_ch,
    output logic [US_W-1:0]   res_us,
    output logic [US_W-1:0]   res_cm,
    output logic [1:0]        res_err
);

    localparam logic [US_W-1:0] TRIG_LAST = US_W'(TRIG_US - 1);
    localparam logic [US_W-1:0] RISE_LAST = US_W'(RISE_TO_US - 1);
    localparam logic [US_W-1:0] ECHO_LAST = US_W'(ECHO_MAX_US - 1);
    localparam logic [US_W-1:0] ECHO_SAT  = US_W'(ECHO_MAX_US);
    localparam logic [US_W-1:0] GAP_LAST  = US_W'(GAP_US - 1);

    state_e            state_q, state_d;
    logic [US_W-1:0]   cnt_q, cnt_d;
    logic [2:0]        ch_q, ch_d;
    logic [CH_NUM-1:0] mask_q, mask_d;
    logic [CH_NUM-1:0] echo_s1_q, echo_s2_q;

    logic [7:0]        echo_pad;
    logic              echo_sel;
    logic [3:0]        nxt;
    logic              trig_on;
    logic              ev_valid;
    logic [US_W-1:0]   ev_us;
    logic [1:0]        ev_err;
    logic [4:0]        res_tag;

    assign echo_pad = 8'(echo_s2_q);
    assign echo_sel = echo_pad[ch_q];
    assign nxt      = next_set(8'(mask_q), ch_q);
    assign busy     = (state_q != ST_IDLE);
    // en gates trig directly so dropping it silences the sensor immediately
    assign trig_on  = (state_q == ST_TRIG) && en;

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_trig
        assign trig[gi] = trig_on && (ch_q == 3'(gi));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        mask_d   = mask_q;
        ev_valid = 1'b0;
        ev_us    = '0;
        ev_err   = ERR_OK;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start && en && (ch_mask != '0)) begin
                    mask_d  = ch_mask;
                    ch_d    = lowest_set(8'(ch_mask));
                    state_d = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (!en) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == TRIG_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RISE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                if (!en) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (echo_sel) begin
                    // the sample that revealed the rise is the first high microsecond
                    cnt_d   = US_W'(1);
                    state_d = ST_MEAS;
                end else if (cnt_q == RISE_LAST) begin
                    ev_valid = 1'b1;
                    ev_err   = ERR_NORISE;
                    cnt_d    = '0;
                    state_d  = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MEAS: begin
                if (!en) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (echo_sel) begin
                    if (cnt_q == ECHO_LAST) begin
                        ev_valid = 1'b1;
                        ev_us    = ECHO_SAT;
                        ev_err   = ERR_LONG;
                        cnt_d    = '0;
                        state_d  = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    ev_valid = 1'b1;
                    ev_us    = cnt_q;
                    cnt_d    = '0;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (!en || (!mode && nxt[3])) begin
                        state_d = ST_IDLE;
                    end else begin
                        ch_d    = nxt[2:0];
                        state_d = ST_TRIG;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1m) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= 3'd0;
            mask_q    <= '0;
            echo_s1_q <= '0;
            echo_s2_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            mask_q    <= mask_d;
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
        end
    end

    sr04_cm_conv #(
        .US_W  (US_W),
        .TAG_W (5)
    ) u_conv (
        .clk_1m    (clk_1m),
        .rst       (rst),
        .in_valid  (ev_valid),
        .in_us     (ev_us),
        .in_tag    ({ev_err, ch_q}),
        .out_valid (res_valid),
        .out_us    (res_us),
        .out_cm    (res_cm),
        .out_tag   (res_tag)
    );

    assign res_err = res_tag[4:3];
    assign res_ch  = res_tag[2:0];

endmodule

// File: tb/tb_sr04_scan_ctrl.sv
// Scoreboard bench for sr04_scan_ctrl with a behavioural sensor model per channel
// and shortened timeouts so every scenario completes quickly.
`timescale 1ns/1ps
module tb_sr04_scan_ctrl;

    localparam int TRIG = 10;
    localparam int RISE = 300;
    localparam int EMAX = 2000;
    localparam int GAP  = 200;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] us;
        logic [15:0] cm;
        logic [1:0]  err;
        int          dly;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en, mode, start;
    logic [3:0]  ch_mask;
    wire  [3:0]  echo;
    logic [3:0]  trig;
    logic        busy, res_valid;
    logic [2:0]  res_ch;
    logic [15:0] res_us, res_cm;
    logic [1:0]  res_err;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rise_dly[4];
    int   echo_w[4];
    int   rise_cnt[4];
    int   fall_cyc[4];
    int   trig_len[4];
    logic [3:0] prev_trig = 4'd0;
    bit   chk_trig_w = 1'b1;
    int   res_count = 0;
    int   last_res_cyc = 0;
    int   prev_res_cyc = 0;
    exp_t sb_q[$];

    sr04_scan_ctrl #(
        .CH_NUM(4), .TRIG_US(TRIG), .RISE_TO_US(RISE),
        .ECHO_MAX_US(EMAX), .GAP_US(GAP), .US_W(16)
    ) dut (
        .clk_1m(clk), .rst(rst), .en(en), .mode(mode), .start(start),
        .ch_mask(ch_mask), .echo(echo), .trig(trig), .busy(busy),
        .res_valid(res_valid), .res_ch(res_ch), .res_us(res_us),
        .res_cm(res_cm), .res_err(res_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sensor model: after trig falls, wait rise_dly then hold echo for echo_w cycles
    for (genvar gi = 0; gi < 4; gi++) begin : g_echo
        logic e = 1'b0;
        assign echo[gi] = e;
        initial forever begin
            @(negedge trig[gi]);
            if (echo_w[gi] > 0) begin
                repeat (rise_dly[gi]) @(negedge clk);
                e = 1'b1;
                repeat (echo_w[gi]) @(negedge clk);
                e = 1'b0;
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            prev_trig = 4'd0;
            for (int c = 0; c < 4; c++) trig_len[c] = 0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (trig[c]) begin
                    if (!prev_trig[c]) rise_cnt[c]++;
                    trig_len[c]++;
                end else if (prev_trig[c]) begin
                    fall_cyc[c] = cyc;
                    if (chk_trig_w) begin
                        total++;
                        if (trig_len[c] != TRIG) begin
                            bad++;
                            $display("FAIL trig_width ch%0d: got %0d cycles, need %0d", c, trig_len[c], TRIG);
                        end
                    end
                    trig_len[c] = 0;
                end
            end
            prev_trig = trig;
            if (res_valid) begin
                prev_res_cyc = last_res_cyc;
                last_res_cyc = cyc;
                res_count++;
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: got ch=%0d us=%0d cm=%0d err=%0d, need none",
                             res_ch, res_us, res_cm, res_err);
                end else begin
                    e = sb_q.pop_front();
                    if (res_ch !== e.ch || res_us !== e.us || res_cm !== e.cm || res_err !== e.err) begin
                        bad++;
                        $display("FAIL result: got ch=%0d us=%0d cm=%0d err=%0d, need ch=%0d us=%0d cm=%0d err=%0d",
                                 res_ch, res_us, res_cm, res_err, e.ch, e.us, e.cm, e.err);
                    end else begin
                        $display("result ch=%0d us=%0d cm=%0d err=%0d ok", res_ch, res_us, res_cm, res_err);
                    end
                    total++;
                    if ((cyc - fall_cyc[e.ch]) != e.dly) begin
                        bad++;
                        $display("FAIL result_latency ch%0d: got %0d cycles after trig fall, need %0d",
                                 e.ch, cyc - fall_cyc[e.ch], e.dly);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input longint got, input longint need);
        total++;
        if (got != need) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d", nm, got, need);
        end else begin
            $display("check %s = %0d ok", nm, got);
        end
    endtask

    task automatic push(input int ch, input int us, input int cm, input int err, input int dly);
        exp_t e;
        e.ch = 3'(ch); e.us = 16'(us); e.cm = 16'(cm); e.err = 2'(err); e.dly = dly;
        sb_q.push_back(e);
    endtask

    task automatic do_start(input logic [3:0] m, input logic md);
        @(negedge clk);
        ch_mask = m;
        mode    = md;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string nm, output int t);
        int n = 0;
        t = -1;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL %s: got busy still high after %0d cycles, need idle", nm, bound);
        end else begin
            t = cyc;
        end
    endtask

    task automatic wait_trig(input int c, input logic lvl, input int bound, input string nm);
        int n = 0;
        while (trig[c] !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (trig[c] !== lvl) begin
            total++;
            bad++;
            $display("FAIL %s: got trig[%0d]=%b after %0d cycles, need %b", nm, c, trig[c], bound, lvl);
        end
    endtask

    task automatic wait_results(input int target, input int bound, input string nm);
        int n = 0;
        while (res_count < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (res_count < target) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d results, need %0d", nm, res_count, target);
        end
    endtask

    initial begin
        int t;
        int base;
        rst = 1'b1; en = 1'b1; mode = 1'b0; start = 1'b0; ch_mask = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {trig, busy, res_valid, res_ch, res_us, res_cm, res_err}, 0);
        rst = 1'b0;

        // 1: single channel, 580 us echo -> 10 cm, busy falls GAP after result
        rise_dly[0] = 5; echo_w[0] = 580;
        push(0, 580, 10, 0, 5 + 580 + 2);
        do_start(4'b0001, 1'b0);
        wait_idle(5000, "t1_idle", t);
        check("t1_busy_after_result", t - last_res_cyc, GAP);
        check("t1_sb_empty", sb_q.size(), 0);

        // 2: mask 1010 pings ch1 then ch3 only; a start while busy is ignored
        rise_dly[1] = 3; echo_w[1] = 1160;
        rise_dly[3] = 8; echo_w[3] = 300;
        for (int c = 0; c < 4; c++) rise_cnt[c] = 0;
        push(1, 1160, 20, 0, 3 + 1160 + 2);
        push(3, 300, 5, 0, 8 + 300 + 2);
        do_start(4'b1010, 1'b0);
        repeat (50) @(negedge clk);
        do_start(4'b1111, 1'b0);
        wait_idle(10000, "t2_idle", t);
        check("t2_trig_rises", {rise_cnt[0][7:0], rise_cnt[1][7:0], rise_cnt[2][7:0], rise_cnt[3][7:0]},
              {8'd0, 8'd1, 8'd0, 8'd1});
        check("t2_sb_empty", sb_q.size(), 0);

        // 3: ch2 never echoes -> err 1 after RISE cycles, scan carries on to ch3
        echo_w[2] = 0;
        rise_dly[3] = 4; echo_w[3] = 300;
        push(2, 0, 0, 1, RISE);
        push(3, 300, 5, 0, 4 + 300 + 2);
        do_start(4'b1100, 1'b0);
        wait_idle(10000, "t3_idle", t);
        check("t3_sb_empty", sb_q.size(), 0);

        // 4: 3000 us echo saturates at EMAX, reported before the fall
        rise_dly[0] = 6; echo_w[0] = 3000;
        push(0, EMAX, 34, 2, 6 + EMAX + 1);
        do_start(4'b0001, 1'b0);
        wait_idle(10000, "t4_idle", t);
        check("t4_sb_empty", sb_q.size(), 0);
        check("t4_echo_still_high", echo[0], 1);
        repeat (1000) @(negedge clk);

        // 5: continuous mode repeats; dropping en mid-MEAS aborts silently
        rise_dly[0] = 20; echo_w[0] = 500;
        push(0, 500, 8, 0, 20 + 500 + 2);
        push(0, 500, 8, 0, 20 + 500 + 2);
        base = res_count;
        do_start(4'b0001, 1'b1);
        wait_results(base + 2, 5000, "t5_results");
        check("t5_period", last_res_cyc - prev_res_cyc, TRIG + 20 + 500 + 2 + GAP);
        wait_trig(0, 1'b1, 2000, "t5_trig_rise");
        wait_trig(0, 1'b0, 100, "t5_trig_fall");
        repeat (20 + 2 + 100) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("t5_abort_trig_busy", {trig, busy}, 0);
        repeat (700) @(negedge clk);
        check("t5_no_result", res_count, base + 2);
        check("t5_sb_empty", sb_q.size(), 0);
        en = 1'b1;

        // 6: reset during TRIG clears everything; start with zero mask is ignored
        echo_w[0] = 0;
        chk_trig_w = 1'b0;
        do_start(4'b0001, 1'b0);
        wait_trig(0, 1'b1, 20, "t6_trig_rise");
        repeat (3) @(negedge clk);
        check("t6_trig_before_rst", trig, 4'b0001);
        rst = 1'b1;
        @(negedge clk);
        check("t6_trig_after_rst", trig, 0);
        check("t6_outputs_after_rst", {busy, res_valid, res_ch, res_us, res_cm, res_err}, 0);
        rst = 1'b0;
        chk_trig_w = 1'b1;
        do_start(4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        check("t6_zero_mask_busy", busy, 0);
        check("final_sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
